// File: rtl/id_gen_if.sv
// Stream bundle between the ID source, id_gen and the downstream checker.
// The out_err wire exists only when IDG_ERR_CHECK_EN is defined.
interface id_gen_if;
  logic       in_valid;
  logic [5:0] in_id;
  logic       in_ready;
  logic       out_valid;
  logic [5:0] out_id;
`ifdef IDG_ERR_CHECK_EN
  logic       out_err;

  modport master (
    output in_valid, in_id,
    input  in_ready, out_valid, out_id, out_err
  );
  modport slave (
    input  in_valid, in_id,
    output in_ready, out_valid, out_id, out_err
  );
`else
  modport master (
    output in_valid, in_id,
    input  in_ready, out_valid, out_id
  );
  modport slave (
    input  in_valid, in_id,
    output in_ready, out_valid, out_id
  );
`endif
endinterface

// File: rtl/id_gen.sv
// National ID generator: collects letter code + N_DIGITS digits, appends the check digit
// and streams the full frame. Optional range checking with out_err: IDG_ERR_CHECK_EN.
module id_gen #(
  parameter int N_DIGITS   = 8,
  parameter int LETTER_MIN = 10,
  parameter int LETTER_MAX = 35
) (
  input logic     clk,
  input logic     rst,
  id_gen_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    EMIT    = 2'd3
  } state_t;

  localparam int IW = $clog2(N_DIGITS + 3);
  localparam logic [IW-1:0] LAST_IDX = IW'(N_DIGITS);
  localparam logic [IW-1:0] CHK_IDX  = IW'(N_DIGITS + 1);
  localparam logic [IW-1:0] END_IDX  = IW'(N_DIGITS + 2);

  state_t        state_r;
  logic [IW-1:0] idx_r;
  logic [IW-1:0] ocnt_r;
  logic [3:0]    sum_r;
  logic [3:0]    check_r;
  logic [5:0]    buf_r [0:N_DIGITS];
  logic          in_ready_r;
  logic          out_valid_r;
  logic [5:0]    out_id_r;
  logic          accept_s;

  // Weighted contribution of one entry, reduced mod 10; entry 0 splits into tens/units.
  function automatic logic [3:0] term_mod10(input logic [5:0] v, input logic [IW-1:0] pos);
    logic [9:0] v_ext;
    logic [9:0] w;
    logic [9:0] p;
    v_ext = {4'd0, v};
    if (pos == '0) begin
      w = 10'd9;
      p = (v_ext / 10'd10) + w * (v_ext % 10'd10);
    end else begin
      w = 10'(N_DIGITS + 1) - 10'(pos);
      p = v_ext * w;
    end
    return 4'(p % 10'd10);
  endfunction

  function automatic logic [3:0] add_mod10(input logic [3:0] a, input logic [3:0] b);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s >= 5'd10) ? 4'(s - 5'd10) : s[3:0];
  endfunction

  function automatic logic entry_bad(input logic [5:0] v, input logic [IW-1:0] pos);
    if (pos == '0) begin
      return (v < 6'(LETTER_MIN)) || (v > 6'(LETTER_MAX));
    end else begin
      return v > 6'd9;
    end
  endfunction

  assign accept_s      = bus.in_valid && in_ready_r && (state_r == COLLECT);
  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_id    = out_id_r;

  // Frame FSM: collect, compute check digit, emit; all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      idx_r       <= '0;
      ocnt_r      <= '0;
      sum_r       <= 4'd0;
      check_r     <= 4'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_id_r    <= 6'd0;
      for (int i = 0; i <= N_DIGITS; i++) begin
        buf_r[i] <= 6'd0;
      end
    end else begin
      case (state_r)
        IDLE: begin
          state_r    <= COLLECT;
          in_ready_r <= 1'b1;
        end
        COLLECT: begin
          if (accept_s) begin
            buf_r[idx_r] <= bus.in_id;
            sum_r        <= add_mod10(sum_r, term_mod10(bus.in_id, idx_r));
            if (idx_r == LAST_IDX) begin
              state_r    <= CHECK;
              in_ready_r <= 1'b0;
              idx_r      <= '0;
            end else begin
              idx_r <= idx_r + 1'b1;
            end
          end else begin
            idx_r <= idx_r;
          end
        end
        CHECK: begin
          check_r     <= (sum_r == 4'd0) ? 4'd0 : 4'd10 - sum_r;
          sum_r       <= 4'd0;
          out_valid_r <= 1'b1;
          out_id_r    <= buf_r[0];
          ocnt_r      <= {{(IW-1){1'b0}}, 1'b1};
          state_r     <= EMIT;
        end
        EMIT: begin
          if (ocnt_r == END_IDX) begin
            out_valid_r <= 1'b0;
            out_id_r    <= 6'd0;
            ocnt_r      <= '0;
            in_ready_r  <= 1'b1;
            state_r     <= COLLECT;
          end else if (ocnt_r == CHK_IDX) begin
            out_id_r <= {2'b00, check_r};
            ocnt_r   <= ocnt_r + 1'b1;
          end else begin
            out_id_r <= buf_r[ocnt_r];
            ocnt_r   <= ocnt_r + 1'b1;
          end
        end
        default: begin
          state_r     <= IDLE;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
          out_id_r    <= 6'd0;
        end
      endcase
    end
  end

`ifdef IDG_ERR_CHECK_EN
  logic err_r;
  logic out_err_r;

  assign bus.out_err = out_err_r;

  // Sticky per-frame range error, reported only on the check-digit beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_r     <= 1'b0;
      out_err_r <= 1'b0;
    end else begin
      if ((state_r == IDLE) || ((state_r == EMIT) && (ocnt_r == END_IDX))) begin
        err_r <= 1'b0;
      end else if (accept_s && entry_bad(bus.in_id, idx_r)) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
      out_err_r <= ((state_r == EMIT) && (ocnt_r == CHK_IDX)) ? err_r : 1'b0;
    end
  end
`else
  // Without range checking, out-of-range entries run through the same arithmetic.
`endif

endmodule

// File: tb/tb_id_gen.sv
// Self-checking bench for id_gen: table of frames fed through a scoreboard,
// plus hand sequences for latency, ignored input and mid-frame reset.
module tb_id_gen;

  typedef struct {
    logic [5:0]  letter;
    logic [31:0] dig;
    logic [3:0]  check;
    int          max_gap;
    bit          garbage;
  } vec_t;

  typedef struct {
    logic [5:0] id;
    logic       err;
  } exp_t;

  logic clk;
  logic rst;
  id_gen_if bus ();

  id_gen dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  vec_t vecs [6];
  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_check(input logic [5:0] l, input logic [31:0] dig);
    int tot;
    tot = (int'(l) / 10) + 9 * (int'(l) % 10);
    for (int k = 0; k < 8; k++) tot += int'(dig[31-4*k -: 4]) * (8 - k);
    return 4'((10 - (tot % 10)) % 10);
  endfunction

  task automatic push_frame(input logic [5:0] letter, input logic [31:0] dig,
                            input logic [3:0] check, input logic err);
    exp_t e;
    e.err = 1'b0;
    e.id = letter;
    sb.push_back(e);
    for (int k = 0; k < 8; k++) begin
      e.id = {2'b00, dig[31-4*k -: 4]};
      sb.push_back(e);
    end
    e.id  = {2'b00, check};
    e.err = err;
    sb.push_back(e);
  endtask

  task automatic send_beat(input logic [5:0] v);
    int t;
    t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("in_ready_timeout", 0, 1);
    bus.in_valid = 1'b1;
    bus.in_id    = v;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_id    = 6'd0;
  endtask

  task automatic send_frame(input logic [5:0] letter, input logic [31:0] dig, input int max_gap);
    send_beat(letter);
    for (int k = 0; k < 8; k++) begin
      if (max_gap > 0) repeat ($urandom_range(1, max_gap)) @(negedge clk);
      send_beat({2'b00, dig[31-4*k -: 4]});
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while (sb.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() > 0) chk("drain_timeout", sb.size(), 0);
  endtask

  // Output monitor: pops the scoreboard on every valid beat, checks idle zeroing otherwise.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_beat", int'(bus.out_id), -1);
        end else begin
          e = sb.pop_front();
          chk("stream_id", int'(bus.out_id), int'(e.id));
`ifdef IDG_ERR_CHECK_EN
          chk("stream_err", int'(bus.out_err), int'(e.err));
`endif
        end
      end else begin
        chk("idle_id_zero", int'(bus.out_id), 0);
      end
    end
  end

  initial begin
    logic [31:0] rd;
    logic [5:0]  rl;

    vecs[0] = '{letter: 6'd10, dig: 32'h12345678, check: 4'd9, max_gap: 0, garbage: 1'b0};
    vecs[1] = '{letter: 6'd11, dig: 32'h00000000, check: 4'd0, max_gap: 0, garbage: 1'b0};
    vecs[2] = '{letter: 6'd10, dig: 32'h99999999, check: 4'd5, max_gap: 3, garbage: 1'b0};
    vecs[3] = '{letter: 6'd23, dig: 32'h98765432, check: 4'd1, max_gap: 1, garbage: 1'b1};
    vecs[4] = '{letter: 6'd35, dig: 32'h00000000, check: 4'd2, max_gap: 0, garbage: 1'b0};
    vecs[5] = '{letter: 6'd17, dig: 32'h00000001, check: 4'd5, max_gap: 2, garbage: 1'b0};

    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_id    = 6'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", int'(bus.in_ready), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_out_id", int'(bus.out_id), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", int'(bus.in_ready), 1);

    for (int i = 0; i < 6; i++) begin
      push_frame(vecs[i].letter, vecs[i].dig, vecs[i].check, 1'b0);
      send_frame(vecs[i].letter, vecs[i].dig, vecs[i].max_gap);
      if (i == 0) begin
        chk("lat_check_cycle", int'(bus.out_valid), 0);
        for (int b = 0; b < 10; b++) begin
          @(negedge clk);
          chk("lat_valid_run", int'(bus.out_valid), 1);
        end
        @(negedge clk);
        chk("lat_valid_end", int'(bus.out_valid), 0);
      end
      if (vecs[i].garbage) begin
        repeat (10) begin
          bus.in_valid = 1'b1;
          bus.in_id    = 6'($urandom_range(0, 63));
          @(negedge clk);
        end
        bus.in_valid = 1'b0;
        bus.in_id    = 6'd0;
      end
      wait_drain();
    end

    for (int r = 0; r < 3; r++) begin
      rl = 6'($urandom_range(10, 35));
      for (int k = 0; k < 8; k++) rd[31-4*k -: 4] = 4'($urandom_range(0, 9));
      push_frame(rl, rd, model_check(rl, rd), 1'b0);
      send_frame(rl, rd, 1);
      wait_drain();
    end

`ifdef IDG_ERR_CHECK_EN
    push_frame(6'd5, 32'h00000000, 4'd5, 1'b1);
    send_frame(6'd5, 32'h00000000, 0);
    wait_drain();
    push_frame(vecs[0].letter, vecs[0].dig, vecs[0].check, 1'b0);
    send_frame(vecs[0].letter, vecs[0].dig, 0);
    wait_drain();
`endif

    // Reset on the 4th emitted beat discards the rest of the frame.
    push_frame(vecs[1].letter, 32'h13572468, model_check(vecs[1].letter, 32'h13572468), 1'b0);
    send_frame(vecs[1].letter, 32'h13572468, 0);
    repeat (4) @(negedge clk);
    chk("rst_mid_beat4_valid", int'(bus.out_valid), 1);
    #1;
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_mid_out_valid", int'(bus.out_valid), 0);
    chk("rst_mid_out_id", int'(bus.out_id), 0);
    chk("rst_mid_in_ready", int'(bus.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_ready_back", int'(bus.in_ready), 1);
    push_frame(vecs[0].letter, vecs[0].dig, vecs[0].check, 1'b0);
    send_frame(vecs[0].letter, vecs[0].dig, 0);
    wait_drain();

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
